// File: rtl/ghost_mode_scheduler_if.sv
// Control/status bundle between the ghost mode scheduler and the ghost movers.
// Signal prefixes are from the scheduler's side: i_ = into the scheduler, o_ = out of it.
interface ghost_mode_scheduler_if;
  logic       i_enable;
  logic       i_pelletEaten;
  logic       o_moveTick;
  logic       o_isScatter;
  logic       o_isChase;
  logic       o_isFrightened;
  logic       o_frightFlash;
  logic       o_dirReverse;
  logic [3:0] o_release;
  logic [2:0] o_phaseIdx;

  modport master (
    output i_enable, i_pelletEaten,
    input  o_moveTick, o_isScatter, o_isChase, o_isFrightened,
    input  o_frightFlash, o_dirReverse, o_release, o_phaseIdx
  );

  modport slave (
    input  i_enable, i_pelletEaten,
    output o_moveTick, o_isScatter, o_isChase, o_isFrightened,
    output o_frightFlash, o_dirReverse, o_release, o_phaseIdx
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Shared move tick, scatter/chase phase schedule, frightened timer and staggered
// house release for the four ghosts. Every output is a register.
module ghost_mode_scheduler #(
  parameter int TICK_DIV     = 416_666,
  parameter int SCAT0        = 420,
  parameter int CHASE0       = 1200,
  parameter int SCAT1        = 420,
  parameter int CHASE1       = 1200,
  parameter int SCAT2        = 300,
  parameter int CHASE2       = 1200,
  parameter int SCAT3        = 300,
  parameter int FRIGHT_TICKS = 360,
  parameter int FLASH_TICKS  = 120,
  parameter int REL_BLINKY   = 0,
  parameter int REL_PINKY    = 60,
  parameter int REL_INKY     = 780,
  parameter int REL_CLYDE    = 1020
) (
  input logic                  clk,
  input logic                  reset,
  ghost_mode_scheduler_if.slave bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(TICK_DIV - 1);
  localparam logic [11:0] FRIGHT_LD = 12'(FRIGHT_TICKS);
  localparam logic [11:0] FLASH_LIM = 12'(FLASH_TICKS);

  typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6, P7} phase_e;

  phase_e           r_phase, w_phaseNxt;
  logic [11:0]      r_phaseCnt, w_phaseCntNxt;
  logic [DIV_W-1:0] r_divCnt;
  logic             r_moveTick;
  logic             r_isScatter, r_isChase, w_scatterNxt, w_chaseNxt;
  logic             r_isFrightened, w_frightNxt;
  logic [11:0]      r_frightCnt, w_frightCntNxt;
  logic             r_frightFlash, w_flashNxt;
  logic             r_dirReverse, w_revNxt;
  logic [10:0]      r_relCnt, w_relCntNxt;
  logic [3:0]       r_release, w_releaseNxt;
  logic             w_tick, w_phaseRun, w_phaseExp;

  // Last tick count of a phase; P7 never expires so its value is unused.
  function automatic logic [11:0] f_dur_last(input phase_e p);
    case (p)
      P0:      f_dur_last = 12'(SCAT0 - 1);
      P1:      f_dur_last = 12'(CHASE0 - 1);
      P2:      f_dur_last = 12'(SCAT1 - 1);
      P3:      f_dur_last = 12'(CHASE1 - 1);
      P4:      f_dur_last = 12'(SCAT2 - 1);
      P5:      f_dur_last = 12'(CHASE2 - 1);
      P6:      f_dur_last = 12'(SCAT3 - 1);
      default: f_dur_last = 12'hFFF;
    endcase
  endfunction

  function automatic logic [10:0] f_sat_inc(input logic [10:0] v);
    f_sat_inc = (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic f_reached(input logic [10:0] cnt, input int lim);
    f_reached = (32'(cnt) >= lim);
  endfunction

  assign w_tick     = r_moveTick & bus.i_enable;
  assign w_phaseRun = w_tick & ~r_isFrightened & (r_phase != P7);
  assign w_phaseExp = w_phaseRun & (r_phaseCnt == f_dur_last(r_phase));

  // Phase FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= P0;
      r_phaseCnt <= '0;
    end else begin
      r_phase    <= w_phaseNxt;
      r_phaseCnt <= w_phaseCntNxt;
    end
  end

  // Phase FSM: next state
  always_comb begin
    w_phaseNxt    = r_phase;
    w_phaseCntNxt = r_phaseCnt;
    if (w_phaseExp) begin
      w_phaseNxt    = phase_e'(r_phase + 3'd1);
      w_phaseCntNxt = '0;
    end else if (w_phaseRun) begin
      w_phaseCntNxt = r_phaseCnt + 12'd1;
    end
  end

  // Phase FSM: output decode (registered below with the other outputs)
  always_comb begin
    w_scatterNxt = ~w_phaseNxt[0];
    w_chaseNxt   = w_phaseNxt[0];
  end

  // A pellet always wins over the countdown, so a repeat pellet simply reloads.
  always_comb begin
    w_frightNxt    = r_isFrightened;
    w_frightCntNxt = r_frightCnt;
    if (bus.i_pelletEaten) begin
      w_frightNxt    = 1'b1;
      w_frightCntNxt = FRIGHT_LD;
    end else if (r_isFrightened && w_tick) begin
      if (r_frightCnt <= 12'd1) begin
        w_frightNxt    = 1'b0;
        w_frightCntNxt = '0;
      end else begin
        w_frightCntNxt = r_frightCnt - 12'd1;
      end
    end
  end

  always_comb begin
    w_flashNxt   = w_frightNxt && (w_frightCntNxt <= FLASH_LIM);
    w_revNxt     = (bus.i_pelletEaten | w_phaseExp) & ~r_dirReverse;
    w_relCntNxt  = w_tick ? f_sat_inc(r_relCnt) : r_relCnt;
    w_releaseNxt = r_release | {f_reached(w_relCntNxt, REL_CLYDE),
                                f_reached(w_relCntNxt, REL_INKY),
                                f_reached(w_relCntNxt, REL_PINKY),
                                f_reached(w_relCntNxt, REL_BLINKY)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_divCnt       <= '0;
      r_moveTick     <= 1'b0;
      r_isScatter    <= 1'b1;
      r_isChase      <= 1'b0;
      r_isFrightened <= 1'b0;
      r_frightCnt    <= '0;
      r_frightFlash  <= 1'b0;
      r_dirReverse   <= 1'b0;
      r_relCnt       <= '0;
      r_release      <= 4'b0000;
    end else begin
      r_divCnt       <= (r_divCnt == DIV_TOP) ? '0 : r_divCnt + 1'b1;
      r_moveTick     <= (r_divCnt == DIV_TOP);
      r_isScatter    <= w_scatterNxt;
      r_isChase      <= w_chaseNxt;
      r_isFrightened <= w_frightNxt;
      r_frightCnt    <= w_frightCntNxt;
      r_frightFlash  <= w_flashNxt;
      r_dirReverse   <= w_revNxt;
      r_relCnt       <= w_relCntNxt;
      r_release      <= w_releaseNxt;
    end
  end

  assign bus.o_moveTick     = r_moveTick;
  assign bus.o_isScatter    = r_isScatter;
  assign bus.o_isChase      = r_isChase;
  assign bus.o_isFrightened = r_isFrightened;
  assign bus.o_frightFlash  = r_frightFlash;
  assign bus.o_dirReverse   = r_dirReverse;
  assign bus.o_release      = r_release;
  assign bus.o_phaseIdx     = r_phase;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed scenarios plus random enable/pellet/reset
// traffic, every cycle compared against a tick-counting reference model.
module tb_ghost_mode_scheduler;
  localparam int TD = 4;
  localparam int FT = 5;
  localparam int FL = 2;
  localparam int DUR [8] = '{3, 2, 1, 1, 1, 1, 1, 0};
  localparam int REL [4] = '{0, 2, 4, 6};

  logic clk = 1'b0;
  logic reset;
  ghost_mode_scheduler_if bus();

  ghost_mode_scheduler #(
    .TICK_DIV(TD), .SCAT0(3), .CHASE0(2), .SCAT1(1), .CHASE1(1),
    .SCAT2(1), .CHASE2(1), .SCAT3(1), .FRIGHT_TICKS(FT), .FLASH_TICKS(FL),
    .REL_BLINKY(0), .REL_PINKY(2), .REL_INKY(4), .REL_CLYDE(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, expressed as elapsed time and tick counts.
  int   m_cyc, m_inph, m_phase, m_frem, m_tot;
  bit   m_tick, m_fr, m_flash, m_rev;
  logic [3:0] m_rel;

  task automatic cmp(string tag, logic [3:0] obs, logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit rst, bit en, bit pel);
    bit counting, adv;
    int sat;
    if (rst) begin
      m_cyc = 0; m_inph = 0; m_phase = 0; m_frem = 0; m_tot = 0;
      m_tick = 0; m_fr = 0; m_flash = 0; m_rev = 0; m_rel = 4'b0000;
      return;
    end
    counting = m_tick && en;
    adv = 0;
    m_cyc++;
    m_tick = (m_cyc % TD == 0);
    if (counting && !m_fr && m_phase < 7) begin
      m_inph++;
      if (m_inph == DUR[m_phase]) begin
        m_phase++;
        m_inph = 0;
        adv = 1;
      end
    end
    if (pel) begin
      m_fr = 1;
      m_frem = FT;
    end else if (m_fr && counting) begin
      m_frem--;
      if (m_frem <= 0) begin
        m_fr = 0;
        m_frem = 0;
      end
    end
    m_rev = (pel || adv) && !m_rev;
    m_flash = m_fr && (m_frem <= FL);
    if (counting) m_tot++;
    sat = (m_tot > 2047) ? 2047 : m_tot;
    for (int i = 0; i < 4; i++) m_rel[i] = (sat >= REL[i]);
  endtask

  task automatic check_all(string tag);
    cmp({tag, ".moveTick"},     {3'b0, bus.o_moveTick},     {3'b0, m_tick});
    cmp({tag, ".isScatter"},    {3'b0, bus.o_isScatter},    {3'b0, (m_phase % 2 == 0)});
    cmp({tag, ".isChase"},      {3'b0, bus.o_isChase},      {3'b0, (m_phase % 2 == 1)});
    cmp({tag, ".isFrightened"}, {3'b0, bus.o_isFrightened}, {3'b0, m_fr});
    cmp({tag, ".frightFlash"},  {3'b0, bus.o_frightFlash},  {3'b0, m_flash});
    cmp({tag, ".dirReverse"},   {3'b0, bus.o_dirReverse},   {3'b0, m_rev});
    cmp({tag, ".release"},      bus.o_release,              m_rel);
    cmp({tag, ".phaseIdx"},     {1'b0, bus.o_phaseIdx},     4'(m_phase));
  endtask

  task automatic step(string tag, bit rst, bit en, bit pel);
    reset = rst;
    bus.i_enable = en;
    bus.i_pelletEaten = pel;
    @(posedge clk);
    model_edge(rst, en, pel);
    #1;
    check_all(tag);
  endtask

  initial begin
    int   guard;
    logic [2:0] held_phase;
    reset = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_pelletEaten = 1'b0;

    // Reset state and the free-running divider with enable low
    repeat (3) step("reset", 1, 0, 0);
    cmp("reset_phaseIdx", {1'b0, bus.o_phaseIdx}, 4'h0);
    cmp("reset_release", bus.o_release, 4'b0000);
    step("idle", 0, 0, 0);
    cmp("release_first_cycle", bus.o_release, 4'b0001);
    cmp("scatter_first_cycle", {3'b0, bus.o_isScatter}, 4'h1);
    repeat (3) step("idle", 0, 0, 0);
    cmp("first_moveTick_cycle4", {3'b0, bus.o_moveTick}, 4'h1);
    repeat (8) step("idle", 0, 0, 0);

    // Full phase schedule run to P7 and held for 20 more ticks
    repeat (40 + 80) step("sched", 0, 1, 0);
    cmp("p7_phaseIdx", {1'b0, bus.o_phaseIdx}, 4'h7);
    cmp("p7_isChase", {3'b0, bus.o_isChase}, 4'h1);
    cmp("p7_release", bus.o_release, 4'b1111);

    // Pellet lands on the same counting tick that ends SCAT0
    step("reset2", 1, 0, 0);
    guard = 0;
    while (!(m_tick && m_tot == 2 && m_phase == 0) && guard < 100) begin
      step("pre_sim", 0, 1, 0);
      guard++;
    end
    cmp("sim_found_tick", {3'b0, (guard < 100)}, 4'h1);
    step("sim_edge", 0, 1, 1);
    cmp("sim_phaseIdx", {1'b0, bus.o_phaseIdx}, 4'h1);
    cmp("sim_frightened", {3'b0, bus.o_isFrightened}, 4'h1);
    cmp("sim_reverse", {3'b0, bus.o_dirReverse}, 4'h1);
    step("sim_after", 0, 1, 0);
    cmp("sim_reverse_drop", {3'b0, bus.o_dirReverse}, 4'h0);
    held_phase = bus.o_phaseIdx;
    repeat (40) step("disabled", 0, 0, 0);
    cmp("disabled_phase_held", {1'b0, bus.o_phaseIdx}, {1'b0, held_phase});
    cmp("disabled_still_fright", {3'b0, bus.o_isFrightened}, 4'h1);

    // Fright expiry, then a second pellet two ticks into a fresh fright
    repeat (30) step("fright_run", 0, 1, 0);
    cmp("fright_expired", {3'b0, bus.o_isFrightened}, 4'h0);
    step("pel1", 0, 1, 1);
    repeat (8) step("pel1_run", 0, 1, 0);
    step("pel2", 0, 1, 1);
    repeat (16) step("pel2_run", 0, 1, 0);
    cmp("fright_extended", {3'b0, bus.o_isFrightened}, 4'h1);
    repeat (20) step("pel2_tail", 0, 1, 0);

    // Reset in the middle of frightened mode
    step("pel3", 0, 1, 1);
    repeat (3) step("pel3_run", 0, 1, 0);
    step("mid_reset", 1, 1, 0);
    cmp("mid_reset_release", bus.o_release, 4'b0000);
    cmp("mid_reset_fright", {3'b0, bus.o_isFrightened}, 4'h0);
    step("post_reset", 0, 1, 0);
    cmp("post_reset_release", bus.o_release, 4'b0001);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom % 400) == 0, ($urandom % 6) != 0, ($urandom % 40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ghost_mode_scheduler.md
# ghost_mode_scheduler

Central timing and mode controller for the four ghost movers. It owns the shared 60 Hz move tick and the scatter/chase phase schedule. It also handles frightened mode after a power pellet and the staggered house-release sequence. Ghost modules consume its outputs instead of each running private dividers and start delays, so all ghosts change mode and step on the same tick.

## Interface
Parameters:
- TICK_DIV, 416_666: clk cycles per move tick (25 MHz / 60 Hz).
- SCAT0, 420 / CHASE0, 1200 / SCAT1, 420 / CHASE1, 1200 / SCAT2, 300 / CHASE2, 1200 / SCAT3, 300: phase durations in move ticks. Phase 7 is chase with no end.
- FRIGHT_TICKS, 360: frightened duration in move ticks.
- FLASH_TICKS, 120: flashing window at the end of frightened mode.
- REL_BLINKY, 0 / REL_PINKY, 60 / REL_INKY, 780 / REL_CLYDE, 1020: release delays in move ticks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; timers advance only when high
- pelletEaten  in  1  one-cycle pulse, power pellet consumed
- moveTick  out  1  one-cycle pulse every TICK_DIV cycles
- isScatter  out  1  scatter phase active
- isChase  out  1  chase phase active
- isFrightened  out  1  frightened mode active
- frightFlash  out  1  last FLASH_TICKS ticks of frightened mode
- dirReverse  out  1  one-cycle pulse; ghosts reverse direction
- release  out  4  per-ghost release flags {clyde, inky, pinky, blinky}, sticky
- phaseIdx  out  3  current phase 0..7

## Operation
- Tick divider:
  - Counter runs 0..TICK_DIV-1 regardless of enable.
  - moveTick is high for the cycle after the counter equals TICK_DIV-1.
- A counting tick is a moveTick cycle with enable high. All timers advance on counting ticks only.
- Phase FSM, states P0..P7:
  - Even phases are scatter; odd phases are chase.
  - phaseCnt (12 bits) increments on each counting tick while not frightened.
  - When phaseCnt == duration-1 on a counting tick: advance phase, clear phaseCnt, pulse dirReverse.
  - P7 holds forever and phaseCnt stops.
- isScatter and isChase are decoded from phaseIdx. Exactly one of them is high at any time, including during frightened mode, so ghosts still know the underlying mode.
- Frightened mode:
  - pelletEaten sets isFrightened, loads frightCnt = FRIGHT_TICKS and pulses dirReverse.
  - frightCnt decrements on counting ticks.
  - At 0, isFrightened clears. No reverse pulse on exit.
  - The phase timer is frozen while frightened.
  - pelletEaten while already frightened reloads frightCnt and pulses dirReverse again.
- frightFlash = isFrightened && frightCnt <= FLASH_TICKS.
- Simultaneous pellet and phase expiry on the same cycle:
  - Phase advances and frightened mode is entered.
  - A single dirReverse pulse is emitted.
- Release:
  - relCnt (11 bits) increments on counting ticks and saturates at 2047.
  - release[i] is set when relCnt >= REL_i and stays set until reset. This makes a 0 delay go high on the first cycle after reset.
- pelletEaten while enable is low is still accepted. The fright timer then waits for enable.

## Timing
- All outputs are registered.
- Reset values:
  - moveTick=0, isScatter=1, isChase=0, isFrightened=0, frightFlash=0, dirReverse=0, release=4'b0000, phaseIdx=0.
  - All counters are 0.
- Reset asserted mid-operation, including mid-frightened: on the next edge all state returns to reset values and the tick divider restarts from 0.
- pelletEaten at cycle n: isFrightened=1 and dirReverse=1 at n+1. dirReverse is low again at n+2.
- Phase advance on the counting tick at cycle n: phaseIdx, isScatter, isChase and dirReverse update at n+1.
- moveTick period is exactly TICK_DIV cycles; first pulse at cycle TICK_DIV after reset release.
- dirReverse is never high for two consecutive cycles.

## Test plan
- Reset, then observe with TICK_DIV=4: moveTick pulses at cycles 4, 8, 12; isScatter=1, phaseIdx=0, release=0001 one cycle after reset.
- SCAT0=3, CHASE0=2, enable=1: isChase rises one cycle after the 3rd tick, with a dirReverse pulse. phaseIdx=2 after 2 further ticks.
- All phases set to 1: phaseIdx reaches 7 after 7 ticks, then stays at 7 with isChase=1 for 20 more ticks and no further dirReverse.
- FRIGHT_TICKS=5, FLASH_TICKS=2:
  - Pellet pulse gives isFrightened=1 next cycle, and phaseCnt is frozen.
  - frightFlash rises after 3 ticks. isFrightened falls after 5 ticks.
  - A second pellet after 2 ticks extends the total to 7 ticks.
- Pellet on the same cycle as SCAT0 expiry: phaseIdx=1, isFrightened=1 and exactly one dirReverse pulse. Then enable=0 for 10 ticks: no counter advances.
- REL_PINKY=2, REL_INKY=4, REL_CLYDE=6: release goes 0011, then 0111, then 1111 on those ticks. Reset mid-fright returns release=0000 and isFrightened=0.
